// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Requester side of the LCD byte-write handshake. After reset it waits out
// the LCD power-up time, sends the HD44780 init list (0x38, 0x0C, 0x01, 0x06),
// then drains a small FIFO of host bytes to the byte-write controller. It
// tracks the cursor column and inserts line-wrap commands on its own
// (0xC0 at column 16, 0x80 at column 32).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   wr_valid   host byte valid
//   wr_rs      host byte type: 0 command, 1 character
//   wr_data    host byte
//   wr_ready   FIFO not full; a byte transfers when wr_valid & wr_ready
//   init_done  init sequence finished, sticky until reset
//   busy       FIFO non-empty, wrap pending, or not idle
//   ctrl_data  byte to the controller
//   ctrl_rs    RS to the controller
//   ctrl_start one-cycle start pulse to the controller
//   ctrl_done  controller done flag (level)
module lcd_cmd_sequencer #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int CLEAR_WAIT     = 82000,
    parameter int DEPTH          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] ctrl_data,
    output logic       ctrl_rs,
    output logic       ctrl_start,
    input  logic       ctrl_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        IDLE,
        POST_WAIT
    } state_t;

    // Where the byte currently in flight came from; decides what happens
    // when its transfer completes.
    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_HOST,
        SRC_WRAP
    } src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic [5:0]  col_q, col_d;
    logic        wrap_pend_q, wrap_pend_d;
    logic [7:0]  wrap_byte_q, wrap_byte_d;
    logic        ret_init_q, ret_init_d;
    logic        init_done_q, init_done_d;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [8:0]    head;
    logic [5:0]    col_inc;
    logic          is_clear;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // DEPTH is a power of two, so the count's top bit alone marks "full".
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign head     = mem[rd_ptr];

    assign col_inc  = col_q + 6'd1;
    // Clear/home commands need the extra settling time after completion.
    assign is_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02);

    assign ctrl_start = (state_q == ISSUE);
    assign ctrl_data  = data_q;
    assign ctrl_rs    = rs_q;
    assign init_done  = init_done_q;
    assign busy       = !(state_q == IDLE && empty && !wrap_pend_q);

    // FIFO storage; contents need no reset because the count governs validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_rs, wr_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PWR_WAIT;
            src_q       <= SRC_INIT;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            col_q       <= '0;
            wrap_pend_q <= 1'b0;
            wrap_byte_q <= 8'h00;
            ret_init_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            col_q       <= col_d;
            wrap_pend_q <= wrap_pend_d;
            wrap_byte_q <= wrap_byte_d;
            ret_init_q  <= ret_init_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic. data/rs are only loaded on the way into ISSUE, which
    // keeps them stable for the whole transfer.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        col_d       = col_q;
        wrap_pend_d = wrap_pend_q;
        wrap_byte_d = wrap_byte_q;
        ret_init_d  = ret_init_q;
        init_done_d = init_done_q;
        pop         = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = INIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            INIT: begin
                if (ctrl_done) begin
                    data_d  = init_byte(init_idx_q);
                    rs_d    = 1'b0;
                    src_d   = SRC_INIT;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                state_d = WAIT_LOW;
            end

            WAIT_LOW: begin
                if (!ctrl_done) state_d = WAIT_HIGH;
            end

            WAIT_HIGH: begin
                if (ctrl_done) begin
                    state_d = IDLE;
                    case (src_q)
                        SRC_INIT: begin
                            init_idx_d = init_idx_q + 2'd1;
                            if (init_idx_q == 2'd3) begin
                                init_done_d = 1'b1;
                                state_d     = IDLE;
                            end else begin
                                state_d = INIT;
                            end
                            if (is_clear) begin
                                ret_init_d = 1'b1;
                                state_d    = POST_WAIT;
                            end
                        end
                        SRC_HOST: begin
                            if (rs_q) begin
                                if (col_inc == 6'd16) begin
                                    col_d       = col_inc;
                                    wrap_pend_d = 1'b1;
                                    wrap_byte_d = 8'hC0;
                                end else if (col_inc == 6'd32) begin
                                    col_d       = '0;
                                    wrap_pend_d = 1'b1;
                                    wrap_byte_d = 8'h80;
                                end else begin
                                    col_d = col_inc;
                                end
                            end else if (is_clear) begin
                                col_d       = '0;
                                wrap_pend_d = 1'b0;
                                ret_init_d  = 1'b0;
                                state_d     = POST_WAIT;
                            end
                        end
                        default: begin
                            // Wrap commands leave the column alone.
                        end
                    endcase
                end
            end

            IDLE: begin
                // A pending wrap blocks the FIFO until it has been sent.
                if (wrap_pend_q) begin
                    if (ctrl_done) begin
                        data_d      = wrap_byte_q;
                        rs_d        = 1'b0;
                        src_d       = SRC_WRAP;
                        wrap_pend_d = 1'b0;
                        state_d     = ISSUE;
                    end
                end else if (!empty && ctrl_done) begin
                    pop     = 1'b1;
                    data_d  = head[7:0];
                    rs_d    = head[8];
                    src_d   = SRC_HOST;
                    state_d = ISSUE;
                end
            end

            POST_WAIT: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = ret_init_q ? INIT : IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer
// Directed bench for lcd_cmd_sequencer with short power-up/clear delays.
// A controller model answers each start pulse by dropping done for three
// cycles; every start is logged with its byte, RS, init_done and cycle.
module tb_lcd_cmd_sequencer;

    localparam int PWR   = 10;
    localparam int CLR   = 5;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       busy;
    logic [7:0] ctrl_data;
    logic       ctrl_rs;
    logic       ctrl_start;
    logic       ctrl_done = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       idn;
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } rec_t;

    rec_t       log_q[$];
    logic [8:0] exp_q[$];
    int         cyc        = 0;
    int         ctr        = 0;
    logic       prev_start = 1'b0;
    logic [8:0] held       = '0;
    int         rel;

    lcd_cmd_sequencer #(
        .POWERUP_CYCLES(PWR),
        .CLEAR_WAIT    (CLR),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_done (init_done),
        .busy      (busy),
        .ctrl_data (ctrl_data),
        .ctrl_rs   (ctrl_rs),
        .ctrl_start(ctrl_start),
        .ctrl_done (ctrl_done)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to measure gaps between start pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model and start-pulse logger, run on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            ctrl_done  = 1'b1;
            ctr        = 0;
            prev_start = 1'b0;
        end else begin
            if (ctr == 1) begin
                checkOutput("hold_until_done", {23'd0, ctrl_rs, ctrl_data}, {23'd0, held});
            end
            if (ctrl_start) begin
                checkOutput("start_one_cycle", {31'd0, prev_start}, 32'd0);
                log_q.push_back('{init_done, ctrl_rs, ctrl_data, cyc});
                held      = {ctrl_rs, ctrl_data};
                ctrl_done = 1'b0;
                ctr       = 3;
            end else if (ctr != 0) begin
                ctr = ctr - 1;
                if (ctr == 0) ctrl_done = 1'b1;
            end
            prev_start = ctrl_start;
        end
    end

    // Push one host byte, waiting (bounded) for room in the FIFO.
    task automatic applyStimulus(input logic rs, input logic [7:0] data);
        int n = 0;
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wr_ready_before_push", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = data;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic checkLog(input string phase);
        logic [8:0] obs;
        checkOutput({phase, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < log_q.size()) ? {log_q[i].rs, log_q[i].data} : 9'h1FF;
            checkOutput($sformatf("%s_xfer%0d", phase, i), {23'd0, obs}, {23'd0, exp_q[i]});
        end
    endtask

    function automatic logic [7:0] chr(input int i);
        return 8'h41 + 8'(i % 26);
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values.
        checkOutput("reset_ctrl_data",  {24'd0, ctrl_data},  32'h00);
        checkOutput("reset_ctrl_rs",    {31'd0, ctrl_rs},    32'd0);
        checkOutput("reset_ctrl_start", {31'd0, ctrl_start}, 32'd0);
        checkOutput("reset_init_done",  {31'd0, init_done},  32'd0);
        checkOutput("reset_busy",       {31'd0, busy},       32'd1);
        checkOutput("reset_wr_ready",   {31'd0, wr_ready},   32'd1);

        // Release reset and fill the FIFO while the power-up wait runs.
        log_q.delete();
        rel   = cyc;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = 8'h61 + 8'(i);
            checkOutput($sformatf("initfill_ready%0d", i), {31'd0, wr_ready}, {31'd0, (i < 4)});
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checkOutput("init_busy",       {31'd0, busy},      32'd1);
        checkOutput("init_done_early", {31'd0, init_done}, 32'd0);

        waitIdle();
        checkOutput("init_done_final", {31'd0, init_done}, 32'd1);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h161, 9'h162, 9'h163, 9'h164};
        checkLog("init");
        if (log_q.size() >= 5) begin
            checkOutput("first_start_cycle", log_q[0].cyc - rel, 32'd11);
            checkOutput("gap_38_0C",        log_q[1].cyc - log_q[0].cyc, 32'd5);
            checkOutput("gap_clear_wait",   log_q[3].cyc - log_q[2].cyc, 32'd10);
            checkOutput("init_done_at_06",  {31'd0, log_q[3].idn}, 32'd0);
            checkOutput("init_done_at_chr", {31'd0, log_q[4].idn}, 32'd1);
        end

        // Clear, then 48 characters: wraps after the 16th, 32nd and 48th.
        log_q.delete();
        exp_q.delete();
        applyStimulus(1'b0, 8'h01);
        exp_q.push_back(9'h001);
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, chr(i));
            exp_q.push_back({1'b1, chr(i)});
            if (i == 15 || i == 47) exp_q.push_back(9'h0C0);
            if (i == 31)            exp_q.push_back(9'h080);
        end
        waitIdle();
        checkLog("wrap");
        if (log_q.size() >= 18) begin
            checkOutput("gap_after_clear", log_q[1].cyc - log_q[0].cyc, 32'd10);
            checkOutput("gap_before_c0",   log_q[17].cyc - log_q[16].cyc, 32'd5);
        end

        // Column at 20, then clear: the wrap must come only after 16 more chars.
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, chr(i + 5));
            exp_q.push_back({1'b1, chr(i + 5)});
        end
        applyStimulus(1'b0, 8'h01);
        exp_q.push_back(9'h001);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, chr(i + 10));
            exp_q.push_back({1'b1, chr(i + 10)});
        end
        exp_q.push_back(9'h0C0);
        waitIdle();
        checkLog("clear");

        // Reset while a transfer sits in WAIT_HIGH with the FIFO full.
        log_q.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h70 + 8'(i));
        end
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(ctrl_done === 1'b0 && ctr == 1) && n < 200);
        checkOutput("found_wait_high",   ctr, 32'd1);
        checkOutput("pre_reset_full",    {31'd0, wr_ready}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("abort_ctrl_data",  {24'd0, ctrl_data},  32'h00);
        checkOutput("abort_ctrl_rs",    {31'd0, ctrl_rs},    32'd0);
        checkOutput("abort_ctrl_start", {31'd0, ctrl_start}, 32'd0);
        checkOutput("abort_init_done",  {31'd0, init_done},  32'd0);
        checkOutput("abort_busy",       {31'd0, busy},       32'd1);
        checkOutput("abort_wr_ready",   {31'd0, wr_ready},   32'd1);
        repeat (2) @(negedge clk);
        log_q.delete();
        reset = 1'b0;

        waitIdle();
        checkOutput("rerun_init_done", {31'd0, init_done}, 32'd1);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
        checkLog("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
